// File: rtl/sdram_fifo_pkg.sv
// sdram_fifo_pkg: shared state encoding and default widths for the SDRAM FIFO scheduler
package sdram_fifo_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam int ADDR_W_D = 24;
  localparam int LEN_W_D = 10;
  localparam int CNT_W_D = 11;
  localparam int RFIFO_DEPTH_D = 1024;
endpackage

// File: rtl/edge_fall_det.sv
// edge_fall_det: one-cycle pulse on a falling edge of d
module edge_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);
  logic d_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) d_q <= 1'b0;
    else d_q <= d;
  assign fall = d_q & ~d;
endmodule

// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: schedules write/read bursts between user FIFOs and sdram_ctrl over ring-buffer regions
module sdram_fifo_ctrl
  import sdram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int LEN_W = LEN_W_D,
  parameter int CNT_W = CNT_W_D,
  parameter int RFIFO_DEPTH = RFIFO_DEPTH_D
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic [ADDR_W-1:0] wr_e_addr,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic              wr_rst,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic [ADDR_W-1:0] rd_e_addr,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic              rd_rst,
  input  logic              rd_valid,
  input  logic [CNT_W-1:0]  wfifo_cnt,
  input  logic [CNT_W-1:0]  rfifo_cnt,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  input  logic              sdram_wr_ack,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  input  logic              sdram_rd_ack,
  output logic              wfifo_rd_en,
  output logic              rfifo_wr_en
);
  state_t state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_adv, rd_adv;
  logic [ADDR_W:0] wr_next, rd_next;
  logic [CNT_W:0] rd_sum;
  logic last_wr, wr_pend, rd_pend, wr_fall, rd_fall, wr_elig, rd_elig;

  edge_fall_det u_wr_fall (.clk(sys_clk), .rst(sys_rst), .d(sdram_wr_ack), .fall(wr_fall));
  edge_fall_det u_rd_fall (.clk(sys_clk), .rst(sys_rst), .d(sdram_rd_ack), .fall(rd_fall));

  assign wfifo_rd_en = sdram_wr_ack;
  assign rfifo_wr_en = sdram_rd_ack;
  assign sdram_wr_addr = wr_ptr;
  assign sdram_rd_addr = rd_ptr;

  assign rd_sum = (CNT_W+1)'(rfifo_cnt) + (CNT_W+1)'(rd_burst_len);
  assign wr_elig = init_end && wr_burst_len != '0 && wfifo_cnt >= CNT_W'(wr_burst_len);
  assign rd_elig = init_end && rd_valid && rd_burst_len != '0 && rd_sum <= (CNT_W+1)'(RFIFO_DEPTH);

  // Wrap on the first pointer at or past the end, even if the last burst overran it
  assign wr_next = (ADDR_W+1)'(wr_ptr) + (ADDR_W+1)'(wr_burst_len);
  assign rd_next = (ADDR_W+1)'(rd_ptr) + (ADDR_W+1)'(rd_burst_len);
  assign wr_adv = wr_next >= {1'b0, wr_e_addr} ? wr_b_addr : wr_next[ADDR_W-1:0];
  assign rd_adv = rd_next >= {1'b0, rd_e_addr} ? rd_b_addr : rd_next[ADDR_W-1:0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      sdram_wr_req <= 1'b0;
      sdram_rd_req <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_wr <= 1'b0;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (wr_elig && (!rd_elig || !last_wr)) begin
            state <= WR;
            sdram_wr_req <= 1'b1;
          end else if (rd_elig) begin
            state <= RD;
            sdram_rd_req <= 1'b1;
          end
        WR:
          if (wr_fall) begin
            state <= IDLE;
            sdram_wr_req <= 1'b0;
            last_wr <= 1'b1;
            wr_pend <= 1'b0;
            wr_ptr <= (wr_pend || wr_rst) ? wr_b_addr : wr_adv;
          end else if (wr_rst) wr_pend <= 1'b1;
        RD:
          if (rd_fall) begin
            state <= IDLE;
            sdram_rd_req <= 1'b0;
            last_wr <= 1'b0;
            rd_pend <= 1'b0;
            rd_ptr <= (rd_pend || rd_rst) ? rd_b_addr : rd_adv;
          end else if (rd_rst) rd_pend <= 1'b1;
        default: state <= IDLE;
      endcase
      // Rewinds outside a burst of the same side take effect immediately
      if (wr_rst && state != WR) wr_ptr <= wr_b_addr;
      if (rd_rst && state != RD) rd_ptr <= rd_b_addr;
    end
  end
endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// tb_sdram_fifo_ctrl: directed self-checking bench for the SDRAM FIFO request scheduler
module tb_sdram_fifo_ctrl;
  logic sys_clk = 1'b0, sys_rst = 1'b1, init_end = 1'b0;
  logic [23:0] wr_b_addr = 24'd0, wr_e_addr = 24'd40, rd_b_addr = 24'd100, rd_e_addr = 24'd200;
  logic [9:0] wr_burst_len = 10'd10, rd_burst_len = 10'd10;
  logic wr_rst = 1'b0, rd_rst = 1'b0, rd_valid = 1'b0;
  logic [10:0] wfifo_cnt = 11'd10, rfifo_cnt = 11'd0;
  logic sdram_wr_req, sdram_rd_req, sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic wfifo_rd_en, rfifo_wr_en;
  int checks = 0, errors = 0;

  sdram_fifo_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr), .wr_burst_len(wr_burst_len), .wr_rst(wr_rst),
    .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr), .rd_burst_len(rd_burst_len), .rd_rst(rd_rst),
    .rd_valid(rd_valid), .wfifo_cnt(wfifo_cnt), .rfifo_cnt(rfifo_cnt),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr), .sdram_rd_ack(sdram_rd_ack),
    .wfifo_rd_en(wfifo_rd_en), .rfifo_wr_en(rfifo_wr_en)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk)
    if (sdram_wr_req && sdram_rd_req) begin
      errors++;
      $error("FAIL both_req observed wr=1 rd=1 expected not both");
    end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic burst(input bit wr, input logic [23:0] exp_addr, input bit rewind);
    for (int i = 0; i < 12 && !(wr ? sdram_wr_req : sdram_rd_req); i++) tick();
    chk(wr ? "wr_req_up" : "rd_req_up", wr ? sdram_wr_req : sdram_rd_req, 1);
    chk(wr ? "wr_addr" : "rd_addr", wr ? sdram_wr_addr : sdram_rd_addr, exp_addr);
    chk("other_req_low", wr ? sdram_rd_req : sdram_wr_req, 0);
    if (wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rewind && i == 2) begin if (wr) wr_rst = 1'b1; else rd_rst = 1'b1; end
      if (rewind && i == 3) begin wr_rst = 1'b0; rd_rst = 1'b0; end
    end
    chk("fifo_strobe", wr ? wfifo_rd_en : rfifo_wr_en, 1);
    chk("req_held", wr ? sdram_wr_req : sdram_rd_req, 1);
    chk("addr_held", wr ? sdram_wr_addr : sdram_rd_addr, exp_addr);
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    tick();
    chk("req_drop", wr ? sdram_wr_req : sdram_rd_req, 0);
  endtask

  initial begin
    #2;
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_wr_addr", sdram_wr_addr, 0);
    chk("rst_rd_addr", sdram_rd_addr, 0);
    tick();
    sys_rst = 1'b0;
    tick();
    tick();
    chk("no_req_before_init", sdram_wr_req, 0);
    init_end = 1'b1;
    tick();
    chk("wr_latency", sdram_wr_req, 1);
    // Four bursts fill the 0..40 region, the fifth wraps to the base
    burst(1, 24'd0, 0);
    burst(1, 24'd10, 0);
    burst(1, 24'd20, 0);
    burst(1, 24'd30, 0);
    burst(1, 24'd0, 0);
    burst(1, 24'd10, 0);
    burst(1, 24'd20, 1);
    burst(1, 24'd0, 0);
    // Async reset in the middle of the next burst at 10
    for (int i = 0; i < 12 && !sdram_wr_req; i++) tick();
    chk("mid_wr_addr", sdram_wr_addr, 10);
    sdram_wr_ack = 1'b1;
    tick();
    tick();
    #2 sys_rst = 1'b1;
    #1 chk("async_drop", sdram_wr_req, 0);
    sdram_wr_ack = 1'b0;
    rd_valid = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("post_rst_wr_ptr", sdram_wr_addr, 0);
    chk("post_rst_rd_ptr", sdram_rd_addr, 0);
    // Both eligible: write wins first tie, then alternate
    burst(1, 24'd0, 0);
    burst(0, 24'd0, 0);
    burst(1, 24'd10, 0);
    wfifo_cnt = 11'd0;
    burst(0, 24'd10, 0);
    rfifo_cnt = 11'd1020;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_gate_full", sdram_rd_req, 0);
    end
    rfifo_cnt = 11'd1014;
    burst(0, 24'd20, 0);
    rd_valid = 1'b0;
    rfifo_cnt = 11'd0;
    wfifo_cnt = 11'd10;
    wr_burst_len = 10'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_valid_gate", sdram_rd_req, 0);
      chk("zero_len_gate", sdram_wr_req, 0);
    end
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    chk("rd_rewind_idle", sdram_rd_addr, 100);
    rd_valid = 1'b1;
    burst(0, 24'd100, 0);
    rd_valid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_fifo_ctrl.md
# sdram_fifo_ctrl

Request scheduler sitting between the user-side write/read FIFOs and `sdram_ctrl`. It watches FIFO fill levels, decides when a full write burst or read burst is due, and drives `sdram_wr_req`/`sdram_rd_req` with ring-buffer addresses. It alternates fairly between write and read and wraps each address pointer inside a programmable region. Only one burst is outstanding at a time; refresh arbitration stays inside `sdram_ctrl`.

## Interface
- `ADDR_W`, 24, SDRAM word address width ({bank, row, col})
- `LEN_W`, 10, burst length width (1..512)
- `CNT_W`, 11, FIFO level width
- `RFIFO_DEPTH`, 1024, read FIFO capacity in words

- `sys_clk` in 1: single clock (100 MHz domain of `sdram_ctrl`)
- `sys_rst` in 1: asynchronous, active-high reset
- `init_end` in 1: SDRAM initialisation done; no request before it is high
- `wr_b_addr`, `wr_e_addr` in ADDR_W: write region base (inclusive) and end (exclusive)
- `wr_burst_len` in LEN_W: words per write burst
- `wr_rst` in 1: 1-cycle pulse; rewind the write pointer to `wr_b_addr`
- `rd_b_addr`, `rd_e_addr` in ADDR_W: read region base and end
- `rd_burst_len` in LEN_W: words per read burst
- `rd_rst` in 1: 1-cycle pulse; rewind the read pointer to `rd_b_addr`
- `rd_valid` in 1: user enables read prefetch
- `wfifo_cnt` in CNT_W: words currently in the write FIFO
- `rfifo_cnt` in CNT_W: words currently in the read FIFO
- `sdram_wr_req` out 1, `sdram_wr_addr` out ADDR_W, `sdram_wr_ack` in 1: write request, address, and data-phase ack to `sdram_ctrl`
- `sdram_rd_req` out 1, `sdram_rd_addr` out ADDR_W, `sdram_rd_ack` in 1: read request, address, and data-phase ack
- `wfifo_rd_en` out 1: equals `sdram_wr_ack` (combinational)
- `rfifo_wr_en` out 1: equals `sdram_rd_ack` (combinational)

## Operation
- **States:** IDLE, WR, RD. Reset state is IDLE. All outputs reset to 0. Both pointers reset to 0.
- **Write eligibility:** `wr_elig` = `init_end` && `wr_burst_len` != 0 && `wfifo_cnt` >= `wr_burst_len`.
- **Read eligibility:** `rd_elig` = `init_end` && `rd_valid` && `rd_burst_len` != 0 && `rfifo_cnt` + `rd_burst_len` <= `RFIFO_DEPTH`. The sum is computed CNT_W+1 bits wide.
- **Transitions from IDLE:**
  - Only one side eligible: go to that side's state.
  - Both eligible: go to the side not served last. The `last_wr` flag resets to 0, so write wins the first tie.
- **In WR:** `sdram_wr_req` = 1 and `sdram_wr_addr` = write pointer, both held stable. On the falling edge of `sdram_wr_ack`:
  - Drop the request and return to IDLE.
  - Set `last_wr` = 1.
  - Advance the write pointer to ptr + `wr_burst_len`. If that result is >= `wr_e_addr`, load `wr_b_addr` instead.
- **In RD:** symmetric with WR, using the `sdram_rd_ack` falling edge, the read pointer, and `last_wr` = 0.
- **Rewind:**
  - `wr_rst` while not in WR: pointer = `wr_b_addr` next cycle.
  - `wr_rst` while in WR: latch a pending flag. On burst end, the rewind is applied instead of the advance.
  - Same rules for `rd_rst`.
- **Eligibility scope:** eligibility is evaluated only in IDLE. Changes to `rd_valid` or FIFO levels during a burst do not abort it.
- **Outstanding requests:** `sdram_wr_req` and `sdram_rd_req` are never both 1.
- **`init_end` low:** no new request is issued. If `init_end` drops mid-burst, the current burst still completes normally.
- **Region bounds:** the region is assumed to be a multiple of burst length. If it is not, the wrap still occurs at the first pointer >= end, so the last burst may overrun `e_addr`. This is documented behaviour.

## Timing
- **Request issue:** registered, asserted the cycle after IDLE sees eligibility, so 1 cycle of latency.
- **Ack edge detect:** ack is delayed by one register; `ack_fall` = delayed & ~ack.
  - Request low and pointer updated on the clock edge following `ack_fall`.
  - The state is IDLE in that same cycle.
- **Minimum gap:** at least 1 IDLE cycle between consecutive requests.
- **FIFO strobes:** `wfifo_rd_en` and `rfifo_wr_en` have zero latency relative to the acks.
- **Reset:** `sys_rst` mid-burst drops both requests immediately (async), clears pointers and `last_wr`, and enters IDLE.

## Structure
- **Package `sdram_fifo_pkg`:**
  - state enum (IDLE/WR/RD, 2-bit);
  - default widths ADDR_W/LEN_W/CNT_W;
  - RFIFO_DEPTH default.
- **Sub-module `edge_fall_det`:** one instance per ack (register + AND). Everything else is flat in a single module.

## Test plan
- **Write burst:** reset, `init_end`=1, `wr_burst_len`=10, `wfifo_cnt`=10, region 0..40.
  - `sdram_wr_req` rises 1 cycle later at addr 0.
  - Ack high for 10 cycles, then the request drops and the next burst goes to addr 10.
- **Write wrap:** four bursts of 10 in region 0..40, then one more → addresses 0, 10, 20, 30, 0.
- **Fairness:** both sides eligible continuously → grants W, R, W, R. `sdram_wr_req` and `sdram_rd_req` are never both high.
- **Read gating:** `rfifo_cnt`=1020, `rd_burst_len`=10 → no `sdram_rd_req`. Drop `rfifo_cnt` to 1014 → request issued. `rd_valid`=0 → no request.
- **Rewind:** `wr_rst` pulsed during a WR burst at addr 20 → after the ack falls, the next write address is `wr_b_addr` (0), not 30.
- **Reset mid-burst:** assert `sys_rst` mid-ack → `sdram_wr_req`=0 in the same cycle. After release, the pointers are 0.
